ifu_fetch: RTL and testbench

- Instruction fetch stage, directly upstream of the instruction ROM (combinational, word-indexed by address>>2) and directly upstream of decode.
- Owns the PC, drives the ROM address and captures the returned word with its PC into a small instruction queue.
- Presents queued instructions to decode over a valid/ready handshake.
- Handles redirects from execute and stops fetching after an ebreak.

---
 rtl/ifu_fetch.sv | 111 +++++++++++
 tb/tb_ifu_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM and queues
// {pc, inst} pairs for decode; handles execute redirects and halts on ebreak.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] EBREAK   = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halt,
  output logic [31:0] inst_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [AW:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0][31:0]  qpc_q, qpc_d, qinst_q, qinst_d;
  logic                    halt_q, halt_d;
  logic [31:0]             cnt_q, cnt_d;

  logic        empty, full, redir, push, pop;
  logic [AW-1:0] ra, wa;
  logic [31:0] redir_tgt;

  assign ra        = rptr_q[AW-1:0];
  assign wa        = wptr_q[AW-1:0];
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wa == ra);
  assign redir     = redirect_valid && (state_q != HALTED);
  assign redir_tgt = redirect_pc & ~32'h3;

  // A redirect kills the head in its own cycle so a stale entry is never accepted.
  assign out_valid  = !empty && !redir && (state_q != HALTED);
  assign pop        = out_valid && out_ready;
  assign push       = (state_q == FETCH) && !redir && (!full || pop);

  assign rom_addr   = pc_q;
  assign out_pc     = qpc_q[ra];
  assign out_inst   = qinst_q[ra];
  assign halt       = halt_q;
  assign inst_count = cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    qpc_d   = qpc_q;
    qinst_d = qinst_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;
    if (redir) begin
      wptr_d  = '0;
      rptr_d  = '0;
      pc_d    = redir_tgt;
      state_d = FETCH;
    end else begin
      if (push) begin
        qpc_d[wa]   = pc_q;
        qinst_d[wa] = rom_inst;
        wptr_d      = wptr_q + (AW+1)'(1);
        pc_d        = pc_q + 32'd4;
        if (rom_inst == EBREAK) state_d = DRAIN;
      end
      if (pop) begin
        rptr_d = rptr_q + (AW+1)'(1);
        cnt_d  = cnt_q + 32'd1;
        // Only the last entry pushed before DRAIN can be the ebreak.
        if (state_q == DRAIN && qinst_q[ra] == EBREAK) begin
          state_d = HALTED;
          halt_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      wptr_q  <= '0;
      rptr_q  <= '0;
      qpc_q   <= '0;
      qinst_q <= '0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      qpc_q   <= qpc_d;
      qinst_q <= qinst_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: ROM model, delivery log and hand-computed expectations.
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr, rom_inst, out_pc, out_inst, redirect_pc, inst_count;
  logic        out_valid, out_ready, redirect_valid, halt;

  logic [31:0] rom [64];
  logic [31:0] got [$];
  int errs = 0;
  int nchk = 0;

  ifu_fetch #(.RESET_PC(32'h0), .DEPTH(2), .EBREAK(32'h0010_0073)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .inst_count(inst_count)
  );

  always #5 clk = ~clk;
  assign rom_inst = rom[rom_addr[7:2]];

  // Log every accepted handshake
  always @(posedge clk)
    if (!rst && out_valid && out_ready) got.push_back(out_pc);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    got.delete();
  endtask

  int seq_ok;
  logic [31:0] cnt_save;

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
    rom[0]  = 32'h0000_0513;
    rom[1]  = 32'h0480_0593;
    rom[12] = 32'h0010_0073;
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    cyc(1);

    // Basic streaming after reset
    do_reset();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_cnt", inst_count, 32'd0);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    cyc(1);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("e0_pc", out_pc, 32'h0);
    chk("e0_inst", out_inst, 32'h0000_0513);
    cyc(1);
    chk("e1_pc", out_pc, 32'h4);
    chk("e1_inst", out_inst, 32'h0480_0593);
    cyc(1);
    chk("e2_pc", out_pc, 32'h8);
    chk("e2_inst", out_inst, 32'h0000_0013);
    cyc(1);
    chk("stream_cnt", inst_count, 32'd3);

    // Stall with a full queue, then release
    out_ready = 1'b0;
    do_reset();
    cyc(5);
    chk("stall_addr", rom_addr, 32'h8);
    chk("stall_pc", out_pc, 32'h0);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_none", got.size(), 32'd0);
    out_ready = 1'b1;
    cyc(3);
    chk("stall_n", got.size(), 32'd3);
    seq_ok = (got.size() == 3 && got[0] == 32'h0 && got[1] == 32'h4 && got[2] == 32'h8) ? 1 : 0;
    chk("stall_seq", seq_ok, 32'd1);

    // Redirect while queue holds 0x4 and 0x8
    out_ready = 1'b0;
    do_reset();
    cyc(3);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    cyc(1);
    chk("pre_redir_pc", out_pc, 32'h4);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0023;
    cnt_save = inst_count;
    #1;
    chk("redir_kill", {31'd0, out_valid}, 32'd0);
    cyc(1);
    redirect_valid = 1'b0;
    chk("redir_next_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_addr", rom_addr, 32'h20);
    cyc(1);
    chk("redir_tgt_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_tgt_pc", out_pc, 32'h20);
    chk("redir_cnt", inst_count, cnt_save);
    cyc(2);
    seq_ok = (got.size() == 3 && got[0] == 32'h0 && got[1] == 32'h20 && got[2] == 32'h24) ? 1 : 0;
    chk("redir_seq", seq_ok, 32'd1);

    // Run to ebreak at 0x30
    do_reset();
    cyc(13);
    chk("pre_halt", {31'd0, halt}, 32'd0);
    cyc(1);
    chk("halt", {31'd0, halt}, 32'd1);
    chk("halt_cnt", inst_count, 32'd13);
    seq_ok = (got.size() == 13) ? 1 : 0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] != 32'(i * 4)) seq_ok = 0;
    chk("halt_seq", seq_ok, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(3);
    chk("halted_valid", {31'd0, out_valid}, 32'd0);
    chk("halted_addr", rom_addr, 32'h34);
    chk("halted_sticky", {31'd0, halt}, 32'd1);
    chk("halted_n", got.size(), 32'd13);

    // Reset out of HALTED
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    got.delete();
    chk("hrst_halt", {31'd0, halt}, 32'd0);
    chk("hrst_cnt", inst_count, 32'd0);
    chk("hrst_valid", {31'd0, out_valid}, 32'd0);
    chk("hrst_addr", rom_addr, 32'h0);
    cyc(1);
    chk("hrst_pc", out_pc, 32'h0);

    // Redirect during DRAIN cancels the ebreak
    do_reset();
    cyc(12);
    chk("drain_head", out_pc, 32'h2C);
    out_ready = 1'b0;
    cyc(1);
    chk("drain_addr", rom_addr, 32'h34);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    #1;
    chk("drain_kill", {31'd0, out_valid}, 32'd0);
    cyc(1);
    redirect_valid = 1'b0;
    cyc(1);
    chk("drain_tgt_pc", out_pc, 32'h10);
    chk("drain_halt", {31'd0, halt}, 32'd0);
    cyc(2);
    seq_ok = 1;
    foreach (got[i]) if (got[i] == 32'h30) seq_ok = 0;
    chk("drain_no_ebreak", seq_ok, 32'd1);
    chk("drain_resume", got[got.size()-1], 32'h14);

    // Reset mid-stall with a full queue and nonzero count
    do_reset();
    cyc(3);
    out_ready = 1'b0;
    cyc(3);
    chk("ms_cnt_pre", inst_count, 32'd2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    got.delete();
    chk("ms_cnt", inst_count, 32'd0);
    chk("ms_valid", {31'd0, out_valid}, 32'd0);
    chk("ms_addr", rom_addr, 32'h0);
    out_ready = 1'b1;
    cyc(2);
    chk("ms_restart", got[0], 32'h0);

    // PC wraps past the top of the address space
    do_reset();
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    cyc(1);
    redirect_valid = 1'b0;
    chk("wrap_addr", rom_addr, 32'hFFFF_FFFC);
    cyc(1);
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", rom_addr, 32'h0);
    cyc(1);
    chk("wrap_pc0", out_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
